// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared 640x480@60 raster constants, decoder state encoding and a wrapping
// position-increment helper for the VGA sync decoder.
// Ports: none (package).
package vga_timing_pkg;

   localparam int unsigned H_TOTAL     = 800;
   localparam int unsigned V_TOTAL     = 525;
   localparam int unsigned H_ACTIVE    = 640;
   localparam int unsigned V_ACTIVE    = 480;
   localparam int unsigned HSYNC_START = 656;
   localparam int unsigned VSYNC_START = 490;

   localparam int unsigned POS_W    = 10;
   localparam int unsigned HCNT_W   = 11;
   localparam int unsigned LCNT_W   = 10;
   localparam int unsigned HCNT_SAT = 1023;

   typedef enum logic [1:0] {
      StSearch,
      StAcquire,
      StLocked
   } dec_state_e;

   // Increment a raster position, wrapping to 0 after the last value.
   function automatic logic [POS_W-1:0] wrap_inc(input logic [POS_W-1:0] pos,
                                                 input logic [POS_W-1:0] last);
      return (pos == last) ? '0 : pos + 1'b1;
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect
// Samples one active-low sync input and flags its falling edge.
// Build option: VGA_DEC_INPUT_SYNC_EN inserts a 2-flop synchronizer (reset to 1)
// ahead of the sampling register; otherwise the input is sampled directly.
// Ports:
//   i_clk   - pixel clock
//   i_rst_n - asynchronous active-low reset
//   i_sig   - raw sync input
//   o_fall  - high for one cycle when the sampled signal goes 1 -> 0
module sync_edge_detect (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_sig,
   output logic o_fall
);

   logic w_in;
   logic r_sample;
   logic r_prev;

`ifdef VGA_DEC_INPUT_SYNC_EN
   logic [1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= 2'b11;
      end else begin
         r_sync <= {r_sync[0], i_sig};
      end
   end

   assign w_in = r_sync[1];
`else
   assign w_in = i_sig;
`endif

   // History resets to 1 so no edge is seen on reset release.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sample <= 1'b1;
         r_prev   <= 1'b1;
      end else begin
         r_sample <= w_in;
         r_prev   <= r_sample;
      end
   end

   assign o_fall = r_prev & ~r_sample;

endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
// Recovers raster position from active-low hsync/vsync, verifies line and frame
// lengths and reports lock, active video, frame start and timing errors.
// Build option: VGA_DEC_INPUT_SYNC_EN (in sync_edge_detect) adds a 2-flop input
// synchronizer, delaying every output by 2 further cycles.
// Ports:
//   clk_25M      - pixel clock
//   reset        - asynchronous active-low reset
//   hsync_in     - active-low horizontal sync
//   vsync_in     - active-low vertical sync
//   h_pos        - recovered horizontal position
//   v_pos        - recovered line number
//   locked       - timing verified
//   active_video - locked and inside the visible area
//   frame_start  - one-cycle pulse at (0,0) while locked
//   timing_error - one-cycle pulse on loss of lock or failed acquire
module vga_sync_decoder
   import vga_timing_pkg::*;
#(
   parameter int unsigned HTotal     = H_TOTAL,
   parameter int unsigned VTotal     = V_TOTAL,
   parameter int unsigned HActive    = H_ACTIVE,
   parameter int unsigned VActive    = V_ACTIVE,
   parameter int unsigned HsyncStart = HSYNC_START,
   parameter int unsigned VsyncStart = VSYNC_START
) (
   input  logic             clk_25M,
   input  logic             reset,
   input  logic             hsync_in,
   input  logic             vsync_in,
   output logic [POS_W-1:0] h_pos,
   output logic [POS_W-1:0] v_pos,
   output logic             locked,
   output logic             active_video,
   output logic             frame_start,
   output logic             timing_error
);

   localparam logic [HCNT_W-1:0] HCntLast  = HCNT_W'(HTotal - 1);
   localparam logic [HCNT_W-1:0] HCntSat   = HCNT_W'(HCNT_SAT);
   localparam logic [LCNT_W-1:0] LCntFrame = LCNT_W'(VTotal);
   localparam logic [LCNT_W-1:0] LCntSat   = '1;
   localparam logic [POS_W-1:0]  HLast     = POS_W'(HTotal - 1);
   localparam logic [POS_W-1:0]  VLast     = POS_W'(VTotal - 1);
   localparam logic [POS_W-1:0]  HAct      = POS_W'(HActive);
   localparam logic [POS_W-1:0]  VAct      = POS_W'(VActive);
   localparam logic [POS_W-1:0]  HLoad     = POS_W'(HsyncStart);
   localparam logic [POS_W-1:0]  VLoad     = POS_W'(VsyncStart);

   logic w_hs_fall;
   logic w_vs_fall;
   logic w_qual;
   logic w_line_err;
   logic w_frame_err;
   logic w_timeout;
   logic w_err;

   dec_state_e        r_state;
   dec_state_e        w_state_next;
   logic              r_vs_pend;
   logic              w_vs_pend_next;
   logic [HCNT_W-1:0] r_h_cnt;
   logic [HCNT_W-1:0] w_h_cnt_next;
   logic [LCNT_W-1:0] r_line_cnt;
   logic [LCNT_W-1:0] w_line_cnt_next;
   logic [POS_W-1:0]  r_h_pos;
   logic [POS_W-1:0]  w_h_pos_next;
   logic [POS_W-1:0]  r_v_pos;
   logic [POS_W-1:0]  w_v_pos_next;
   logic              r_locked;
   logic              r_active;
   logic              r_frame_start;
   logic              r_timing_error;

   sync_edge_detect u_hs_edge (
      .i_clk   (clk_25M),
      .i_rst_n (reset),
      .i_sig   (hsync_in),
      .o_fall  (w_hs_fall)
   );

   sync_edge_detect u_vs_edge (
      .i_clk   (clk_25M),
      .i_rst_n (reset),
      .i_sig   (vsync_in),
      .o_fall  (w_vs_fall)
   );

   // A vsync edge in the same cycle as hs_fall qualifies that hs_fall directly.
   assign w_qual      = w_hs_fall & (r_vs_pend | w_vs_fall);
   assign w_line_err  = w_hs_fall & (r_h_cnt != HCntLast);
   // r_line_cnt holds the lines since the previous qualified hs_fall.
   assign w_frame_err = w_qual & (r_line_cnt != LCntFrame);
   assign w_timeout   = (r_h_cnt == HCntSat);

   always_comb begin
      w_vs_pend_next = r_vs_pend;
      w_h_cnt_next   = r_h_cnt;
      w_line_cnt_next = r_line_cnt;
      w_h_pos_next   = wrap_inc(r_h_pos, HLast);
      w_v_pos_next   = r_v_pos;

      if (w_hs_fall) begin
         w_vs_pend_next = 1'b0;
      end else if (w_vs_fall) begin
         w_vs_pend_next = 1'b1;
      end

      if (w_hs_fall) begin
         w_h_cnt_next = '0;
      end else if (r_h_cnt != HCntSat) begin
         w_h_cnt_next = r_h_cnt + 1'b1;
      end

      // Restart at 1 so the current line is already counted.
      if (w_qual) begin
         w_line_cnt_next = LCNT_W'(1);
      end else if (w_hs_fall && (r_line_cnt != LCntSat)) begin
         w_line_cnt_next = r_line_cnt + 1'b1;
      end

      if (w_hs_fall) begin
         w_h_pos_next = HLoad;
      end

      if (w_qual) begin
         w_v_pos_next = VLoad;
      end else if (w_hs_fall) begin
         w_v_pos_next = wrap_inc(r_v_pos, VLast);
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_err        = 1'b0;
      unique case (r_state)
         StSearch: begin
            if (w_qual) begin
               w_state_next = StAcquire;
            end
         end
         StAcquire: begin
            if (w_line_err || w_frame_err || w_timeout) begin
               w_err        = 1'b1;
               w_state_next = StSearch;
            end else if (w_qual) begin
               w_state_next = StLocked;
            end
         end
         StLocked: begin
            if (w_line_err || w_frame_err || w_timeout) begin
               w_err        = 1'b1;
               w_state_next = StSearch;
            end
         end
         default: w_state_next = StSearch;
      endcase
   end

   // Flags are derived from next-state values so they line up with h_pos/v_pos.
   always_ff @(posedge clk_25M or negedge reset) begin
      if (!reset) begin
         r_state        <= StSearch;
         r_vs_pend      <= 1'b0;
         r_h_cnt        <= '0;
         r_line_cnt     <= '0;
         r_h_pos        <= '0;
         r_v_pos        <= '0;
         r_locked       <= 1'b0;
         r_active       <= 1'b0;
         r_frame_start  <= 1'b0;
         r_timing_error <= 1'b0;
      end else begin
         r_state        <= w_state_next;
         r_vs_pend      <= w_vs_pend_next;
         r_h_cnt        <= w_h_cnt_next;
         r_line_cnt     <= w_line_cnt_next;
         r_h_pos        <= w_h_pos_next;
         r_v_pos        <= w_v_pos_next;
         r_locked       <= (w_state_next == StLocked);
         r_active       <= (w_state_next == StLocked) && (w_h_pos_next < HAct) &&
                           (w_v_pos_next < VAct);
         r_frame_start  <= (w_state_next == StLocked) && (w_h_pos_next == '0) &&
                           (w_v_pos_next == '0);
         r_timing_error <= w_err;
      end
   end

   assign h_pos        = r_h_pos;
   assign v_pos        = r_v_pos;
   assign locked       = r_locked;
   assign active_video = r_active;
   assign frame_start  = r_frame_start;
   assign timing_error = r_timing_error;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder
// Scoreboard bench for vga_sync_decoder on a reduced 40x12 raster (32x8 visible,
// hsync at 34, vsync at line 9). Expected output events (lock change,
// frame_start, timing_error) are queued with their position and the number of
// active_video cycles since the previous event; a monitor pops and compares.
module tb_vga_sync_decoder;

   localparam int HT    = 40;
   localparam int VT    = 12;
   localparam int HA    = 32;
   localparam int VA    = 8;
   localparam int HSS   = 34;
   localparam int VSS   = 9;
   localparam int STALL = 1100;
   localparam int FULL  = HA * VA;

   logic       clk_25M = 1'b0;
   logic       reset;
   logic       hsync_in;
   logic       vsync_in;
   logic [9:0] h_pos;
   logic [9:0] v_pos;
   logic       locked;
   logic       active_video;
   logic       frame_start;
   logic       timing_error;

   initial forever #5 clk_25M = ~clk_25M;

   vga_sync_decoder #(
      .HTotal     (HT),
      .VTotal     (VT),
      .HActive    (HA),
      .VActive    (VA),
      .HsyncStart (HSS),
      .VsyncStart (VSS)
   ) u_dut (
      .clk_25M      (clk_25M),
      .reset        (reset),
      .hsync_in     (hsync_in),
      .vsync_in     (vsync_in),
      .h_pos        (h_pos),
      .v_pos        (v_pos),
      .locked       (locked),
      .active_video (active_video),
      .frame_start  (frame_start),
      .timing_error (timing_error)
   );

   typedef struct {
      bit fs;
      bit te;
      bit lk;
      int h;
      int v;
      int act;
   } ev_t;

   ev_t exp_q[$];
   int  n_checks = 0;
   int  n_fail   = 0;

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic push_ev(input bit fs, input bit te, input bit lk, input int h, input int v,
                          input int act);
      ev_t e;
      e.fs  = fs;
      e.te  = te;
      e.lk  = lk;
      e.h   = h;
      e.v   = v;
      e.act = act;
      exp_q.push_back(e);
   endtask

   task automatic push_lock();
      push_ev(1'b0, 1'b0, 1'b1, HSS, VSS, 0);
   endtask

   task automatic push_frame(input int act);
      push_ev(1'b1, 1'b0, 1'b1, 0, 0, act);
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".h_pos"}, int'(h_pos), 0);
      check({tag, ".v_pos"}, int'(v_pos), 0);
      check({tag, ".locked"}, int'(locked), 0);
      check({tag, ".active_video"}, int'(active_video), 0);
      check({tag, ".frame_start"}, int'(frame_start), 0);
      check({tag, ".timing_error"}, int'(timing_error), 0);
   endtask

   // Monitor: every lock change, frame_start or timing_error sample is an event.
   initial begin
      bit lk_prev;
      int act_cnt;
      int ev_idx;
      lk_prev = 1'b0;
      act_cnt = 0;
      ev_idx  = 0;
      forever begin
         @(negedge clk_25M);
         if (frame_start || timing_error || (locked != lk_prev)) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_event%0d: fs=%0d te=%0d lk=%0d h=%0d v=%0d, required none",
                        ev_idx, frame_start, timing_error, locked, h_pos, v_pos);
            end else begin
               ev_t e;
               e = exp_q.pop_front();
               check($sformatf("ev%0d.frame_start", ev_idx), int'(frame_start), int'(e.fs));
               check($sformatf("ev%0d.timing_error", ev_idx), int'(timing_error), int'(e.te));
               check($sformatf("ev%0d.locked", ev_idx), int'(locked), int'(e.lk));
               check($sformatf("ev%0d.h_pos", ev_idx), int'(h_pos), e.h);
               check($sformatf("ev%0d.v_pos", ev_idx), int'(v_pos), e.v);
               check($sformatf("ev%0d.active_cycles", ev_idx), act_cnt, e.act);
            end
            ev_idx++;
            act_cnt = 0;
         end
         if (active_video) act_cnt++;
         lk_prev = locked;
      end
   end

   task automatic drive(input bit hs, input bit vs);
      @(posedge clk_25M);
      #1;
      hsync_in = hs;
      vsync_in = vs;
   endtask

   // One raster frame; optional long line, optional stall (hsync held high).
   task automatic gen_frame(input int n_lines, input int long_line, input int long_len,
                            input int stall_line, input bit vs_early);
      for (int gy = 0; gy < n_lines; gy++) begin
         int len;
         if (gy == stall_line) begin
            repeat (STALL) drive(1'b1, 1'b1);
            return;
         end
         len = (gy == long_line) ? long_len : HT;
         for (int gx = 0; gx < len; gx++) begin
            bit hs;
            bit vs;
            hs = !(gx >= HSS && gx < HSS + 4);
            vs = !((gy == VSS && gx >= (vs_early ? 0 : HSS)) || gy == VSS + 1);
            drive(hs, vs);
         end
      end
   endtask

   initial begin
      reset    = 1'b0;
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      repeat (3) @(negedge clk_25M);
      check_zero("reset");
      @(posedge clk_25M);
      #1;
      reset = 1'b1;

      // Nominal frames: lock after the second qualified hs_fall (coincident edges).
      push_lock();
      push_frame(0);
      push_frame(FULL);
      push_frame(FULL);
      repeat (5) gen_frame(VT, -1, HT, -1, 1'b0);

      // One 41-clock line while locked, then relock.
      push_frame(FULL);
      push_ev(1'b0, 1'b1, 1'b0, HSS, 4, 4 * HA);
      push_lock();
      push_frame(0);
      gen_frame(VT, 3, HT + 1, -1, 1'b0);
      repeat (2) gen_frame(VT, -1, HT, -1, 1'b0);

      // hsync stuck high while locked: error when h_cnt reaches 1023.
      push_frame(FULL);
      push_ev(1'b0, 1'b1, 1'b0, (HSS + 1024) % HT, 1, HA + 818);
      gen_frame(VT, -1, HT, 2, 1'b0);

      // Short frame while acquiring: error, no lock; then relock.
      push_ev(1'b0, 1'b1, 1'b0, HSS, VSS, 0);
      push_lock();
      push_frame(0);
      gen_frame(VT - 1, -1, HT, -1, 1'b0);
      repeat (3) gen_frame(VT, -1, HT, -1, 1'b0);
      gen_frame(5, -1, HT, -1, 1'b0);

      // Reset mid-frame while locked: lock drops without timing_error.
      push_ev(1'b0, 1'b0, 1'b0, 0, 0, 4 * HA);
      @(posedge clk_25M);
      #1;
      reset    = 1'b0;
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      @(negedge clk_25M);
      check_zero("midframe_reset");
      repeat (4) @(posedge clk_25M);
      #1;
      reset = 1'b1;

      // Relock with vsync leading hsync (pending vsync path).
      push_lock();
      push_frame(0);
      push_frame(FULL);
      repeat (4) gen_frame(VT, -1, HT, -1, 1'b1);

      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk_25M);
      check("events_pending", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have port clk_25M, input, 1 bit: pixel clock; the only clock.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port hsync_in, input, 1 bit: active-low horizontal sync from the timing generator.
REQ-004 SHALL have port vsync_in, input, 1 bit: active-low vertical sync from the timing generator.
REQ-005 SHALL have port h_pos, output, 10 bits: recovered horizontal position, 0..799.
REQ-006 SHALL have port v_pos, output, 10 bits: recovered line number, 0..524.
REQ-007 SHALL have port locked, output, 1 bit: high while the timing is verified.
REQ-008 SHALL have port active_video, output, 1 bit: high when locked, h_pos<640 and v_pos<480.
REQ-009 SHALL have port frame_start, output, 1 bit: one-cycle pulse when locked, h_pos==0 and v_pos==0.
REQ-010 SHALL have port timing_error, output, 1 bit: one-cycle pulse on any loss of lock or acquire failure.

Function
REQ-011 SHALL detect the hsync falling edge (hs_fall) as 1 on the sampled signal in the previous cycle and 0 in the current cycle.
REQ-012 SHALL detect the vsync falling edge the same way and latch it in vs_pend until the next hs_fall, which consumes it.
REQ-013 SHALL count clocks since the last hs_fall in h_cnt (11 bits), clear it on hs_fall and saturate it at 1023.
REQ-014 SHALL treat an hs_fall with h_cnt+1 != H_TOTAL (800) as a line-length error.
REQ-015 SHALL increment a line counter on each hs_fall and treat a vs_pend-qualified hs_fall with line count != V_TOTAL (525) as a frame-length error.
REQ-016 SHALL treat a vsync fall coinciding with hs_fall as qualifying that same hs_fall.
REQ-017 SHALL implement the states SEARCH, ACQUIRE and LOCKED.
REQ-018 SHALL transition SEARCH->ACQUIRE on the first vs_pend-qualified hs_fall; no error is evaluated in SEARCH.
REQ-019 SHALL transition ACQUIRE->LOCKED on the next vs_pend-qualified hs_fall when no error has occurred.
REQ-020 SHALL go to SEARCH and pulse timing_error for 1 cycle from ACQUIRE or LOCKED on: a line error, a frame error, or h_cnt reaching 1023 (timeout).
REQ-021 SHALL load h_pos with HSYNC_START (656) on hs_fall; otherwise h_pos SHALL increment, wrapping 799->0.
REQ-022 SHALL load v_pos with VSYNC_START (490) on a qualified hs_fall; on other hs_fall v_pos SHALL increment, wrapping 524->0.
REQ-023 SHALL register locked, active_video and frame_start, giving a latency of 1 clock after the sampled sync edge.
REQ-024 SHALL hold active_video and frame_start at 0 in SEARCH and ACQUIRE; h_pos and v_pos keep running in all states.

Reset
REQ-025 SHALL, while reset is low, asynchronously force state=SEARCH, h_pos=0, v_pos=0, all counters=0, vs_pend=0, edge history=1, and locked, active_video, frame_start and timing_error=0.
REQ-026 SHALL produce no timing_error pulse on reset assertion or release, including mid-frame.

Configuration
REQ-027 SHALL, with VGA_DEC_INPUT_SYNC_EN defined, pass hsync_in and vsync_in through a 2-flop synchronizer reset to 1, adding 2 cycles to all latencies.
REQ-028 SHALL, without VGA_DEC_INPUT_SYNC_EN, sample hsync_in and vsync_in directly with a single register.

Structure
REQ-029 SHALL take H_TOTAL, V_TOTAL, H_ACTIVE=640, V_ACTIVE=480, HSYNC_START, VSYNC_START and the state enum from the shared package vga_timing_pkg.
REQ-030 SHALL implement optional synchronizer plus falling-edge detection as sub-module sync_edge_detect, instantiated once per sync input.

Verification
REQ-031 SHALL verify nominal 800x525 timing for 3 frames -> locked rises 1 cycle after the 2nd qualified hs_fall; frame_start pulses once per frame; 640x480 active_video cycles per frame.
REQ-032 SHALL verify one 801-clock line while LOCKED -> timing_error pulses 1 cycle, locked=0, relock after 2 further good frames.
REQ-033 SHALL verify hsync held high for 1100 clocks while LOCKED -> timing_error at h_cnt=1023, state SEARCH.
REQ-034 SHALL verify a 524-line frame in ACQUIRE -> timing_error pulses, no lock.
REQ-035 SHALL verify vsync and hsync falling in the same cycle -> v_pos=490 and h_pos=656 on the following cycle.
REQ-036 SHALL verify reset pulsed mid-frame while LOCKED -> all outputs 0, no timing_error, relock after 2 frames.
